// File: rtl/divider4bit_seq_if.sv
// Handshake/result bundle for the sequential restoring divider.
//   start     : request, sampled only when the divider is not busy
//   dividend  : unsigned dividend, sampled with an accepted start
//   divisor   : unsigned divisor, sampled with an accepted start
//   busy      : high while a division is in progress
//   done      : one-cycle pulse, results valid/updated
//   quotient  : unsigned quotient, held until the next completion
//   remainder : unsigned remainder, held until the next completion
//   div_by_zero : set with done when divisor was 0, held with results
interface divider4bit_seq_if #(
    parameter int unsigned N = 4
) ();
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    // Requester side: issues operands, observes results.
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    // Divider side.
    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/divider4bit_seq.sv
// Sequential restoring divider, one quotient bit per clock.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : divider4bit_seq_if slave modport (start/operands in, busy/done/results out)
// A division by zero skips the iteration and completes in the next cycle with
// quotient all ones, remainder = dividend and div_by_zero set.
module divider4bit_seq #(
    parameter int unsigned N = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    divider4bit_seq_if.slave       bus
);

    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  q_q, q_d;        // dividend shifting out / quotient shifting in
    logic [N-1:0]  d_q, d_d;        // latched divisor
    logic [N:0]    r_q, r_d;        // partial remainder, one guard bit
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  quot_q, quot_d;
    logic [N-1:0]  rem_q, rem_d;
    logic          dbz_q, dbz_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [N:0]    r_shift;
    logic [N:0]    trial;
    logic [N:0]    r_next;
    logic [N-1:0]  q_next;

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            d_q     <= d_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state, restoring step and result loading.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        d_d     = d_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        // Shift in the next dividend bit, then try subtracting the divisor;
        // a set guard bit means the trial went negative and is discarded.
        r_shift = {r_q[N-1:0], q_q[N-1]};
        trial   = r_shift - {1'b0, d_q};
        r_next  = trial[N] ? r_shift : trial;
        q_next  = {q_q[N-2:0], ~trial[N]};

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    q_d   = bus.dividend;
                    d_d   = bus.divisor;
                    r_d   = '0;
                    cnt_d = '0;
                    if (bus.divisor != '0) begin
                        state_d = CALC;
                    end else begin
                        state_d = DONE;
                        quot_d  = '1;
                        rem_d   = bus.dividend;
                        dbz_d   = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                q_d   = q_next;
                r_d   = r_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = DONE;
                    quot_d  = q_next;
                    rem_d   = r_next[N-1:0];
                    dbz_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == CALC);
        done_d = (state_d == DONE);
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider4bit_seq.sv
// Self-checking bench for divider4bit_seq: directed scenarios plus an
// exhaustive 4-bit sweep with random idle gaps, checked against plain
// integer division.
module tb_divider4bit_seq;

    localparam int unsigned N = 4;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    divider4bit_seq_if #(.N(N)) dif ();

    divider4bit_seq #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock and sample just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands with start for one edge; returns just after that edge.
    task automatic start_div(input logic [N-1:0] a, input logic [N-1:0] b);
        dif.start    = 1'b1;
        dif.dividend = a;
        dif.divisor  = b;
        tick();
        dif.start = 1'b0;
    endtask

    // Called just after the accepting edge; checks busy/done cycle by cycle
    // and the results in the done cycle, against integer division.
    task automatic wait_done(input logic [N-1:0] a, input logic [N-1:0] b);
        int unsigned lat;
        int unsigned eq, er, edbz;
        lat = (b == 0) ? 0 : N;
        if (b == 0) begin
            eq   = (1 << N) - 1;
            er   = a;
            edbz = 1;
        end else begin
            eq   = a / b;
            er   = a % b;
            edbz = 0;
        end
        for (int k = 0; k < int'(lat); k++) begin
            check("busy_calc", 32'(dif.busy), 32'd1);
            check("done_early", 32'(dif.done), 32'd0);
            tick();
        end
        check("done", 32'(dif.done), 32'd1);
        check("busy_done", 32'(dif.busy), 32'd0);
        check("quotient", 32'(dif.quotient), 32'(eq));
        check("remainder", 32'(dif.remainder), 32'(er));
        check("div_by_zero", 32'(dif.div_by_zero), 32'(edbz));
        if (b != 0) begin
            check("invariant", 32'(dif.quotient) * 32'(b) + 32'(dif.remainder), 32'(a));
            check("rem_lt_div", 32'(dif.remainder < b), 32'd1);
        end
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        dif.start    = 1'b0;
        dif.dividend = '0;
        dif.divisor  = '0;
        rst          = 1'b1;
        #12;
        check("rst_busy", 32'(dif.busy), 32'd0);
        check("rst_done", 32'(dif.done), 32'd0);
        check("rst_q", 32'(dif.quotient), 32'd0);
        check("rst_r", 32'(dif.remainder), 32'd0);
        check("rst_dbz", 32'(dif.div_by_zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // 13 / 3
        start_div(4'd13, 4'd3);
        wait_done(4'd13, 4'd3);
        tick();
        check("done_pulse", 32'(dif.done), 32'd0);

        // 15 / 1 then back-to-back 5 / 7 started in the done cycle
        start_div(4'd15, 4'd1);
        wait_done(4'd15, 4'd1);
        start_div(4'd5, 4'd7);
        wait_done(4'd5, 4'd7);
        tick();

        // 7 / 0, then 9 / 4
        start_div(4'd7, 4'd0);
        check("dbz_busy", 32'(dif.busy), 32'd0);
        wait_done(4'd7, 4'd0);
        tick();
        check("dbz_pulse", 32'(dif.done), 32'd0);
        start_div(4'd9, 4'd4);
        wait_done(4'd9, 4'd4);
        tick();

        // 12 / 5 with start and operand noise during CALC
        start_div(4'd12, 4'd5);
        dif.start    = 1'b1;
        dif.dividend = 4'd3;
        dif.divisor  = 4'd3;
        tick();
        dif.start    = 1'b0;
        dif.dividend = 4'd9;
        dif.divisor  = 4'd2;
        check("noise_busy", 32'(dif.busy), 32'd1);
        tick();
        dif.dividend = 4'd1;
        dif.divisor  = 4'd0;
        tick();
        check("noise_no_done", 32'(dif.done), 32'd0);
        tick();
        check("noise_done", 32'(dif.done), 32'd1);
        check("noise_q", 32'(dif.quotient), 32'd2);
        check("noise_r", 32'(dif.remainder), 32'd2);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("noise_extra_done", 32'(dif.done), 32'd0);
        end

        // 14 / 3 aborted by reset on the second CALC cycle
        start_div(4'd14, 4'd3);
        tick();
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(dif.busy), 32'd0);
        check("abort_done", 32'(dif.done), 32'd0);
        check("abort_q", 32'(dif.quotient), 32'd0);
        check("abort_r", 32'(dif.remainder), 32'd0);
        check("abort_dbz", 32'(dif.div_by_zero), 32'd0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("abort_no_done", 32'(dif.done), 32'd0);
        end
        start_div(4'd14, 4'd3);
        wait_done(4'd14, 4'd3);
        tick();

        // Exhaustive sweep with random idle gaps (0 = start in done cycle).
        for (int b = 0; b < (1 << N); b++) begin
            for (int a = 0; a < (1 << N); a++) begin
                int unsigned gap;
                start_div(N'(a), N'(b));
                wait_done(N'(a), N'(b));
                gap = $urandom_range(0, 3);
                for (int g = 0; g < int'(gap); g++) begin
                    tick();
                end
            end
        end

        // Random operands with random gaps.
        for (int i = 0; i < 40; i++) begin
            logic [N-1:0] ra, rb;
            ra = N'($urandom);
            rb = N'($urandom);
            start_div(ra, rb);
            wait_done(ra, rb);
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
